load_store_unit: RTL

Load/store unit between the single-cycle core datapath and a variable-latency data memory. Takes the ALU-computed address, store data and funct3 from the core. Drives a word-addressed request/ready memory port with byte enables, and returns a sign- or zero-extended load result. Holds the core with `Stall` until the access completes, and flags misaligned or illegal accesses and bus timeouts.

---
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: core-side load/store sequencer for a
// word-addressed request/ready data memory with timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessFault,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    lo_q;
  logic [31:0]   rdata_q;

  logic          start;
  logic          legal;
  logic          go;
  logic          fault;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ld_v;

  assign start = MemRead | MemWrite;

  // access legality: width vs. alignment, funct3 range
  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      MemWrite: begin
        unique case (Funct3)
          3'b000:  legal = 1'b1;
          3'b001:  legal = ~Addr[0];
          3'b010:  legal = (Addr[1:0] == 2'b00);
          default: legal = 1'b0;
        endcase
      end
      default: begin
        unique case (Funct3)
          3'b000,
          3'b100:  legal = 1'b1;
          3'b001,
          3'b101:  legal = ~Addr[0];
          3'b010:  legal = (Addr[1:0] == 2'b00);
          default: legal = 1'b0;
        endcase
      end
    endcase
  end

  // byte enables and lane-replicated write data
  always_comb begin
    be_n = 4'b1111;
    wd_n = WrData;
    unique case (Funct3[1:0])
      2'b00: begin
        be_n = 4'b0001 << Addr[1:0];
        wd_n = {4{WrData[7:0]}};
      end
      2'b01: begin
        be_n = Addr[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{WrData[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = WrData;
      end
    endcase
  end

  // lane extraction and sign/zero extension of the read word
  always_comb begin
    byte_v = 8'(mem_rdata >> {lo_q, 3'b000});
    half_v = lo_q[1] ? mem_rdata[31:16]
                     : mem_rdata[15:0];
    unique case (f3_q)
      3'b000:  ld_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  ld_v = {24'd0, byte_v};
      3'b001:  ld_v = {{16{half_v[15]}}, half_v};
      3'b101:  ld_v = {16'd0, half_v};
      default: ld_v = mem_rdata;
    endcase
  end

  assign go    = (state == IDLE) & start & legal;
  assign fault = reset & (state == IDLE)
               & start & ~legal;

  assign Stall       = reset & (go | (state == REQ));
  assign AccessFault = fault;
  assign ReadData    = fault ? 32'd0 : rdata_q;
  assign mem_req     = (state == REQ);

  // access sequencer: capture, wait for ready or timeout, retire
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= 3'd0;
      lo_q      <= 2'd0;
      rdata_q   <= 32'd0;
      BusErr    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'b0000;
    end else begin
      BusErr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state     <= REQ;
            cnt       <= '0;
            f3_q      <= Funct3;
            lo_q      <= Addr[1:0];
            mem_we    <= MemWrite;
            mem_addr  <= {Addr[31:2], 2'b00};
            mem_wdata <= wd_n;
            mem_be    <= be_n;
          end
        end
        REQ: begin
          if (mem_ready) begin
            state   <= DONE;
            rdata_q <= mem_we ? 32'd0 : ld_v;
          end else if (cnt == CW'(TIMEOUT)) begin
            state   <= DONE;
            rdata_q <= 32'd0;
            BusErr  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
